// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master controller among
// NUM_REQ requesters; single-byte read/write, registered outputs.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req/req_addr/       per-requester request level, 7-bit address,
//   req_data/req_rw     write byte and direction (1 = read)
//   gnt, ack, err       one-hot grant, done pulse, timeout pulse
//   rdata               last byte read back
//   busy                arbiter not idle
//   ctl_*               controller enable/addr/data_in/rw, data_out,
//                       ready and done handshake
//
// Optional: define ARB_TIMEOUT_EN to build a 16-bit watchdog that
// abandons a transaction after TIMEOUT_CYCLES ISSUE cycles and
// pulses err instead of ack. Without it err is tied to zero.

module i2c_bus_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_rw,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   err,
  output logic [7:0]           rdata,
  output logic                 busy,
  output logic                 ctl_enable,
  output logic [6:0]           ctl_addr,
  output logic [7:0]           ctl_data,
  output logic                 ctl_rw,
  input  logic [7:0]           ctl_data_out,
  input  logic                 ctl_ready,
  input  logic                 ctl_done
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RELEASE
  } state_t;

  state_t               state_q;
  logic [IW-1:0]        last_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic [7:0]           rdata_q;
  logic                 busy_q;
  logic                 en_q;
  logic [6:0]           addr_q;
  logic [7:0]           data_q;
  logic                 rw_q;

  logic                 hi_found;
  logic                 lo_found;
  logic [IW-1:0]        hi_idx;
  logic [IW-1:0]        lo_idx;
  logic                 any_req;
  logic [IW-1:0]        win_idx;
  logic [NUM_REQ-1:0]   win_oh;
  logic [6:0]           win_addr;
  logic [7:0]           win_data;
  logic                 win_rw;

  // Round-robin: prefer the lowest set index above last_q,
  // otherwise wrap to the lowest set index at or below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        if (i > int'(last_q)) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = IW'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = IW'(i);
        end
      end
    end
    any_req = hi_found | lo_found;
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    win_oh   = '0;
    win_addr = '0;
    win_data = '0;
    win_rw   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == win_idx) begin
        win_oh[i] = 1'b1;
        win_addr  = req_addr[i*7 +: 7];
        win_data  = req_data[i*8 +: 8];
        win_rw    = req_rw[i];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]        wd_q;
  logic [NUM_REQ-1:0] err_q;
  assign err = err_q;
`else
  assign err = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      gnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= '0;
`endif
    end else begin
      ack_q <= '0;
`ifdef ARB_TIMEOUT_EN
      err_q <= '0;
`endif
      unique case (state_q)
        IDLE: begin
          if (any_req && ctl_ready) begin
            gnt_q   <= win_oh;
            addr_q  <= win_addr;
            data_q  <= win_data;
            rw_q    <= win_rw;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            last_q  <= win_idx;
            state_q <= ISSUE;
`ifdef ARB_TIMEOUT_EN
            wd_q    <= '0;
`endif
          end
        end
        ISSUE: begin
          // done has priority over a coinciding watchdog expiry
          if (ctl_done) begin
            en_q    <= 1'b0;
            ack_q   <= gnt_q;
            state_q <= RELEASE;
            if (rw_q) begin
              rdata_q <= ctl_data_out;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (wd_q == WD_LAST) begin
            en_q    <= 1'b0;
            err_q   <= gnt_q;
            state_q <= RELEASE;
          end else begin
            wd_q <= wd_q + 16'd1;
          end
`endif
        end
        RELEASE: begin
          if (ctl_ready) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign ctl_enable = en_q;
  assign ctl_addr   = addr_q;
  assign ctl_data   = data_q;
  assign ctl_rw     = rw_q;

endmodule
